// File: rtl/lfsr16_rr_sched.sv
// Shared 16-bit Fibonacci LFSR word source with warm-up sequencer and a
// round-robin arbiter that delivers one word per grant to NREQ requesters.
module lfsr16_rr_sched #(
    parameter int          NREQ = 4,
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          WARM = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            seed_load_i,
    input  logic [15:0]     seed_in_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            rnd_valid_o,
    output logic [15:0]     rnd_data_o,
    output logic            busy_o,
    output logic [15:0]     gnt_count_o
);
    localparam int PW = $clog2(NREQ);
    localparam logic [7:0] WARM_LAST = 8'((WARM == 0) ? 0 : WARM - 1);

    typedef enum logic {WARMUP, RUN} state_t;
    localparam state_t RST_STATE = (WARM == 0) ? RUN : WARMUP;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [7:0]      warm_q, warm_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            vld_q, vld_d;
    logic [15:0]     data_q, data_d;
    logic [15:0]     cnt_q, cnt_d;

    // Round-robin search: first set request at or above ptr, wrapping.
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        warm_d  = warm_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        vld_d   = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (seed_load_i) begin
            // An all-zero seed would lock the LFSR, so fall back to SEED.
            lfsr_d  = (seed_in_i == 16'h0000) ? SEED : seed_in_i;
            warm_d  = '0;
            state_d = RST_STATE;
        end else if (state_q == WARMUP) begin
            lfsr_d = lfsr_next(lfsr_q);
            warm_d = warm_q + 8'd1;
            if (warm_q == WARM_LAST) state_d = RUN;
        end else if (win_found) begin
            gnt_d  = NREQ'(1) << win_idx;
            vld_d  = 1'b1;
            data_d = lfsr_q;
            lfsr_d = lfsr_next(lfsr_q);
            ptr_d  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            cnt_d  = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RST_STATE;
            lfsr_q  <= SEED;
            warm_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            warm_q  <= warm_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rnd_valid_o = vld_q;
    assign rnd_data_o  = data_q;
    assign busy_o      = (state_q == WARMUP);
    assign gnt_count_o = cnt_q;
endmodule

// File: tb/tb_lfsr16_rr_sched.sv
// Bench for lfsr16_rr_sched: one instance with WARM=0 and one with WARM=2,
// driven from vector tables with expectations checked through a scoreboard.
module tb_lfsr16_rr_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, sl0, rst2, sl2;
    logic [15:0] si0, si2;
    logic [3:0]  req0, req2;
    logic [3:0]  g0, g2;
    logic        v0, v2, b0, b2;
    logic [15:0] d0, d2, c0, c2;

    lfsr16_rr_sched #(.NREQ(4), .SEED(16'hACE1), .WARM(0)) dut0 (
        .clk_i(clk), .reset_i(rst0), .seed_load_i(sl0), .seed_in_i(si0),
        .req_i(req0), .gnt_o(g0), .rnd_valid_o(v0), .rnd_data_o(d0),
        .busy_o(b0), .gnt_count_o(c0));

    lfsr16_rr_sched #(.NREQ(4), .SEED(16'hACE1), .WARM(2)) dut2 (
        .clk_i(clk), .reset_i(rst2), .seed_load_i(sl2), .seed_in_i(si2),
        .req_i(req2), .gnt_o(g2), .rnd_valid_o(v2), .rnd_data_o(d2),
        .busy_o(b2), .gnt_count_o(c2));

    typedef struct {
        logic [3:0]  req;
        logic        sl;
        logic [15:0] si;
        logic [3:0]  gnt;
        logic        v;
        logic [15:0] data;
        logic [15:0] cnt;
        logic        busy;
    } vec_t;

    vec_t sb[$];
    vec_t tbl0[13];
    vec_t tbl2[8];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic logic [15:0] step(input logic [15:0] q);
        logic fb;
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
        return {q[14:0], fb};
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one vector on the selected instance, push its expectation,
    // then pop and compare once the registered outputs have updated.
    task automatic apply(input int d, input string tag, input vec_t t);
        vec_t e;
        if (d == 0) begin req0 = t.req; sl0 = t.sl; si0 = t.si; end
        else        begin req2 = t.req; sl2 = t.sl; si2 = t.si; end
        sb.push_back(t);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        if (d == 0) begin
            cmp({tag, ".gnt"},  16'(g0), 16'(e.gnt));
            cmp({tag, ".vld"},  16'(v0), 16'(e.v));
            cmp({tag, ".data"}, d0, e.data);
            cmp({tag, ".cnt"},  c0, e.cnt);
            cmp({tag, ".busy"}, 16'(b0), 16'(e.busy));
        end else begin
            cmp({tag, ".gnt"},  16'(g2), 16'(e.gnt));
            cmp({tag, ".vld"},  16'(v2), 16'(e.v));
            cmp({tag, ".data"}, d2, e.data);
            cmp({tag, ".cnt"},  c2, e.cnt);
            cmp({tag, ".busy"}, 16'(b2), 16'(e.busy));
        end
        if (d == 0) sl0 = 1'b0; else sl2 = 1'b0;
    endtask

    initial begin
        logic [15:0] m;
        // WARM=0 stream after reset: rotation, skipping, idle hold, reseeds.
        tbl0[0]  = '{4'b1111, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'hACE1, 16'd1, 1'b0};
        tbl0[1]  = '{4'b1111, 1'b0, 16'h0000, 4'b0010, 1'b1, 16'h59C3, 16'd2, 1'b0};
        tbl0[2]  = '{4'b1111, 1'b0, 16'h0000, 4'b0100, 1'b1, 16'hB387, 16'd3, 1'b0};
        tbl0[3]  = '{4'b1111, 1'b0, 16'h0000, 4'b1000, 1'b1, 16'h670F, 16'd4, 1'b0};
        tbl0[4]  = '{4'b1111, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'hCE1E, 16'd5, 1'b0};
        tbl0[5]  = '{4'b1001, 1'b0, 16'h0000, 4'b1000, 1'b1, 16'h9C3C, 16'd6, 1'b0};
        tbl0[6]  = '{4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h9C3C, 16'd6, 1'b0};
        tbl0[7]  = '{4'b0110, 1'b0, 16'h0000, 4'b0010, 1'b1, 16'h3879, 16'd7, 1'b0};
        tbl0[8]  = '{4'b0001, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'h70F2, 16'd8, 1'b0};
        tbl0[9]  = '{4'b1111, 1'b1, 16'h1234, 4'b0000, 1'b0, 16'h70F2, 16'd8, 1'b0};
        tbl0[10] = '{4'b1111, 1'b0, 16'h0000, 4'b0010, 1'b1, 16'h1234, 16'd9, 1'b0};
        tbl0[11] = '{4'b0100, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'h1234, 16'd9, 1'b0};
        tbl0[12] = '{4'b0100, 1'b0, 16'h0000, 4'b0100, 1'b1, 16'hACE1, 16'd10, 1'b0};
        // WARM=2: warm-up after reset, then a reseed mid-stream.
        m = step(step(16'h1234));
        tbl2[0] = '{4'b0001, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 16'd0, 1'b1};
        tbl2[1] = '{4'b0001, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl2[2] = '{4'b0001, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'hB387, 16'd1, 1'b0};
        tbl2[3] = '{4'b0001, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'h670F, 16'd2, 1'b0};
        tbl2[4] = '{4'b0001, 1'b1, 16'h1234, 4'b0000, 1'b0, 16'h670F, 16'd2, 1'b1};
        tbl2[5] = '{4'b0001, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h670F, 16'd2, 1'b1};
        tbl2[6] = '{4'b0001, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h670F, 16'd2, 1'b0};
        tbl2[7] = '{4'b0001, 1'b0, 16'h0000, 4'b0001, 1'b1, m,        16'd3, 1'b0};

        rst0 = 1'b1; sl0 = 1'b0; si0 = '0; req0 = '0;
        rst2 = 1'b1; sl2 = 1'b0; si2 = '0; req2 = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst0.gnt",  16'(g0), 16'h0);
        cmp("rst0.vld",  16'(v0), 16'h0);
        cmp("rst0.data", d0, 16'h0000);
        cmp("rst0.cnt",  c0, 16'h0000);
        cmp("rst0.busy", 16'(b0), 16'h0);
        cmp("rst2.busy", 16'(b2), 16'h1);
        rst0 = 1'b0;

        for (int i = 0; i < 13; i++) apply(0, $sformatf("w0[%0d]", i), tbl0[i]);

        rst2 = 1'b0;
        for (int i = 0; i < 8; i++) apply(2, $sformatf("w2[%0d]", i), tbl2[i]);

        // Count wrap: 65535 grants, then the 65536th reads back as zero.
        rst0 = 1'b1; req0 = 4'b0001;
        @(posedge clk); #1;
        rst0 = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        cmp("wrap.pre_cnt", c0, 16'hFFFF);
        m = 16'hACE1;
        for (int i = 0; i < 65535; i++) m = step(m);
        apply(0, "wrap", '{4'b0001, 1'b0, 16'h0000, 4'b0001, 1'b1, m, 16'h0000, 1'b0});

        // Reset mid-RUN with req still held drops the in-flight grant.
        rst0 = 1'b1;
        apply(0, "midrst", '{4'b0001, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 16'h0000, 1'b0});
        rst0 = 1'b0;
        apply(0, "post_rst", '{4'b0001, 1'b0, 16'h0000, 4'b0001, 1'b1, 16'hACE1, 16'd1, 1'b0});

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr16_rr_sched.md
# lfsr16_rr_sched

Shared pseudo-random word source for the course-project datapath. The block owns a 16-bit Fibonacci LFSR and a warm-up sequencer. It also contains a round-robin arbiter that hands one LFSR word per grant to up to NREQ requesters. It supports run-time reseeding and lock-up protection, and keeps a running count of delivered words.

## Interface
- NREQ, 4: number of requesters, 2..8.
- SEED, 16'hACE1: reset seed; also substituted for any all-zero seed.
- WARM, 16: LFSR steps run after reset or reseed before any grant, 0..255.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- seed_load  input  1  one-cycle strobe that loads seed_in.
- seed_in  input  16  new seed value.
- req  input  NREQ  level request per requester; held high means continuous demand.
- gnt  output  NREQ  registered one-hot grant, valid for one cycle.
- rnd_valid  output  1  high in the same cycle as any gnt bit.
- rnd_data  output  16  random word for the granted requester; holds its last value when rnd_valid is low.
- busy  output  1  high while in WARMUP.
- gnt_count  output  16  total grants since reset; wraps at 16'hFFFF to 0.

## Operation
- LFSR step:
  - fb = q[15]^q[13]^q[12]^q[10] (x^16+x^14+x^13+x^11+1).
  - next = {q[14:0], fb}.
  - Example: 16'hACE1 -> 16'h59C3 -> 16'hB387.
- Zero guard: a seed_in of 16'h0000 loads SEED instead. The all-zero state is therefore unreachable.
- States:
  - WARMUP: the LFSR steps every cycle and a warm counter counts to WARM. No grants are issued and busy=1. Go to RUN once WARM steps have completed. If WARM=0, WARMUP is skipped.
  - RUN: arbitrate every cycle.
- Grant in RUN, any req bit set, seed_load low:
  - The winner is the first set req bit, searching upward from pointer ptr with wrap.
  - Registered effects on the next edge: gnt=onehot(winner), rnd_valid=1, rnd_data=current lfsr, lfsr=next(lfsr), ptr=winner+1 (mod NREQ), gnt_count+1.
- No request in RUN: the LFSR holds (it does not free-run), gnt=0, rnd_valid=0, and ptr is unchanged.
- seed_load, any state, highest priority below reset:
  - No grant that cycle.
  - Next edge: lfsr=seed (zero-guarded), warm counter=0, state=WARMUP, or RUN if WARM=0.
  - ptr and gnt_count are kept.
- seed_load during WARMUP restarts warm-up from the new seed.
- A requester that drops req before being granted is simply skipped; there is no queued state.

## Timing
- Reset values:
  - lfsr=SEED, ptr=0, warm counter=0.
  - state=WARMUP (RUN if WARM=0), busy=1 (0 if WARM=0).
  - gnt=0, rnd_valid=0, rnd_data=16'h0000, gnt_count=0.
- Request-to-grant latency: req sampled at edge t gives gnt/rnd_data at t+1.
- Throughput: one word per cycle. A single requester holding req is granted every cycle.
- Reset to first grant: WARM+1 cycles with req held. The first word is SEED advanced WARM steps.
- seed_load at edge t:
  - The first grant can occur at edge t+WARM+2 with req held.
  - gnt is 0 at edge t+1.
- Reset asserted mid-RUN: all outputs return to reset values on the next edge; any in-flight gnt is dropped.
- gnt_count wraps from 16'hFFFF to 16'h0000 on the 65536th grant, with no flag.

## Test plan
- Reset with WARM=0, req=4'b0001 held: rnd_data is 16'hACE1, then 16'h59C3, then 16'hB387 on consecutive cycles; gnt=4'b0001 each cycle; gnt_count goes 1,2,3.
- WARM=0, req=4'b1111 held for 5 cycles after reset: gnt sequence 0001, 0010, 0100, 1000, 0001, with each requester receiving a distinct consecutive LFSR word.
- WARM=2, req held from reset: busy=1 for 2 cycles, then busy falls; the first grant carries 16'hB387.
- seed_load with seed_in=16'h0000 and WARM=0: the next grant delivers 16'hACE1, and gnt=0 on the cycle after the strobe.
- seed_load with seed_in=16'h1234 mid-stream with req held: grant is suppressed for one cycle, then rnd_data=16'h1234; ptr continues from the last winner.
- Preload 65535 grants, or force gnt_count, then one more grant: gnt_count reads 16'h0000. Assert reset mid-RUN: gnt, rnd_valid and rnd_data read 0 on the next cycle.
